// File: rtl/axi_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R). LANES > 1 packs per-requester slices side by side,
// slice k occupying bits [k*W +: W] of each field.
interface axi_rd_arbiter_if #(
  parameter int LANES  = 1,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
) ();
  logic [LANES*ID_W-1:0]   arid;
  logic [LANES*ADDR_W-1:0] araddr;
  logic [LANES*8-1:0]      arlen;
  logic [LANES*3-1:0]      arsize;
  logic [LANES*2-1:0]      arburst;
  logic [LANES*3-1:0]      arprot;
  logic [LANES-1:0]        arvalid;
  logic [LANES-1:0]        arready;
  logic [LANES*ID_W-1:0]   rid;
  logic [LANES*DATA_W-1:0] rdata;
  logic [LANES*2-1:0]      rresp;
  logic [LANES-1:0]        rlast;
  logic [LANES-1:0]        rvalid;
  logic [LANES-1:0]        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// N upstream read masters share one downstream AXI read port: round-robin AR grant into a
// one-entry slice with the grant index prefixed onto ARID; R beats are steered back by that prefix.
// Define AXI_RD_ARB_OUTSTANDING_LIMIT_EN to cap outstanding bursts per requester at MAX_OUTSTANDING.
module axi_rd_arbiter #(
  parameter int  N               = 2,
  parameter int  ID_WIDTH        = 4,
  parameter int  ADDR_WIDTH      = 64,
  parameter int  DATA_WIDTH      = 512,
  parameter int  MAX_OUTSTANDING = 8,
  localparam int SEL_W           = (N > 1) ? $clog2(N) : 1
) (
  input logic              clk,
  input logic              rst,
  axi_rd_arbiter_if.slave  s_axi,
  axi_rd_arbiter_if.master m_axi
);

  localparam int MID_W = ID_WIDTH + SEL_W;

  logic                  slice_load;
  logic [N-1:0]          eligible;
  logic                  grant_found;
  logic [SEL_W-1:0]      grant_idx;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_sel_ok;

  logic                  slice_full_q, slice_full_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [MID_W-1:0]      arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [2:0]            arprot_q, arprot_d;

`ifdef AXI_RD_ARB_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [N-1:0]     ar_hs;
  logic [N-1:0]     r_last_hs;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_comb begin
    ar_hs     = s_axi.arvalid & s_axi.arready;
    r_last_hs = s_axi.rvalid & s_axi.rready & {N{m_axi.rlast}};
    eligible  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]    = cnt_q[i];
      eligible[i] = s_axi.arvalid[i] & (cnt_q[i] != CNT_W'(MAX_OUTSTANDING));
      // A grant is never issued at the cap, so the increment cannot overflow.
      if (ar_hs[i] & ~r_last_hs[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (r_last_hs[i] & ~ar_hs[i] & (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end
`else
  // Without counters only a degenerate zero cap could block a requester.
  always_comb eligible = (MAX_OUTSTANDING > 0) ? s_axi.arvalid : '0;
`endif

  always_comb begin
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    slice_load  = ~slice_full_q | m_axi.arready;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(off);
      if (sum >= (SEL_W+1)'(N)) sum = sum - (SEL_W+1)'(N);
      idx = sum[SEL_W-1:0];
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    s_axi.arready = '0;
    if (slice_load && grant_found && !rst) s_axi.arready[grant_idx] = 1'b1;
  end

  always_comb begin
    slice_full_d = slice_full_q;
    rr_ptr_d     = rr_ptr_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arprot_d     = arprot_q;
    if (slice_load) begin
      slice_full_d = grant_found;
      if (grant_found) begin
        arid_d    = {grant_idx, s_axi.arid[int'(grant_idx)*ID_WIDTH +: ID_WIDTH]};
        araddr_d  = s_axi.araddr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        arlen_d   = s_axi.arlen[int'(grant_idx)*8 +: 8];
        arsize_d  = s_axi.arsize[int'(grant_idx)*3 +: 3];
        arburst_d = s_axi.arburst[int'(grant_idx)*2 +: 2];
        arprot_d  = s_axi.arprot[int'(grant_idx)*3 +: 3];
        rr_ptr_d  = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_full_q <= 1'b0;
      rr_ptr_q     <= '0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arprot_q     <= '0;
    end else begin
      slice_full_q <= slice_full_d;
      rr_ptr_q     <= rr_ptr_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arprot_q     <= arprot_d;
    end
  end

  assign m_axi.arvalid = slice_full_q;
  assign m_axi.arid    = arid_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = arsize_q;
  assign m_axi.arburst = arburst_q;
  assign m_axi.arprot  = arprot_q;

  // Beats whose prefix names no requester are sunk so the downstream port never stalls.
  always_comb begin
    r_sel        = m_axi.rid[MID_W-1:ID_WIDTH];
    r_sel_ok     = ({1'b0, r_sel} < (SEL_W+1)'(N));
    s_axi.rvalid = '0;
    m_axi.rready = 1'b1;
    if (r_sel_ok) begin
      s_axi.rvalid[r_sel] = m_axi.rvalid;
      m_axi.rready        = s_axi.rready[r_sel];
    end
  end

  assign s_axi.rid   = {N{m_axi.rid[ID_WIDTH-1:0]}};
  assign s_axi.rdata = {N{m_axi.rdata}};
  assign s_axi.rresp = {N{m_axi.rresp}};
  assign s_axi.rlast = {N{m_axi.rlast}};

endmodule
